// File: rtl/mem_image_loader.sv
// Streams a {base, count, data...} image into the mirrored IM/DM byte banks.
// The CPU is held in reset until a zero-count header ends the image.
module mem_image_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [31:0]       words_loaded,
  output logic [31:0]       checksum
);
  // state    | meaning
  // IDLE     | out of reset, waiting for start
  // HDR_BASE | expecting a block base word
  // HDR_CNT  | expecting a block word count (0 ends the image)
  // DATA     | writing block data words
  // DONE     | image complete, CPU released
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_BASE = 3'd1,
    HDR_CNT  = 3'd2,
    DATA     = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              xfer;
  logic              session_start;

  assign xfer          = s_valid & s_ready;
  assign session_start = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = HDR_BASE;
      HDR_BASE: if (xfer) state_nx = HDR_CNT;
      HDR_CNT:  if (xfer) state_nx = (s_data[ADDR_W:0] == '0) ? DONE : DATA;
      DATA:     if (xfer && remaining == REM_ONE) state_nx = HDR_BASE;
      DONE:     if (start) state_nx = HDR_BASE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    case (state)
      HDR_BASE, HDR_CNT, DATA: s_ready = 1'b1;
      default:                 s_ready = 1'b0;
    endcase
  end

  // Datapath and status flags; status is registered on the same edge as the state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ptr          <= '0;
      remaining    <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      mem_we <= '0;
      if (session_start) begin
        cpu_rst      <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        words_loaded <= '0;
        checksum     <= '0;
      end
      if (state_nx == DONE && state != DONE) begin
        cpu_rst <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
      end
      case (state)
        HDR_BASE: if (xfer) ptr <= s_data[ADDR_W-1:0];
        HDR_CNT:  if (xfer) remaining <= s_data[ADDR_W:0];
        DATA: if (xfer) begin
          mem_we       <= 4'hF;
          mem_addr     <= ptr;
          mem_wdata    <= s_data;
          ptr          <= ptr + PTR_ONE;
          remaining    <= remaining - REM_ONE;
          words_loaded <= words_loaded + 32'd1;
          checksum     <= checksum + s_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_image_loader.sv
// Random image streams against a queue-based write model; a monitor pops
// the expected write whenever the loader pulses mem_we.
module tb_mem_image_loader;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_ready;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic [31:0]       words_loaded;
  logic [31:0]       checksum;

  mem_image_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .words_loaded(words_loaded), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          n_cmp = 0;
  int          n_err = 0;
  wr_t         exp_q[$];
  logic [31:0] dq[$];
  logic [31:0] exp_words;
  logic [31:0] exp_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst === 1'b0 && mem_we !== 4'h0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_we", 32'(mem_we), 32'hF);
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
  end

  // Called at a negedge; returns at a negedge after the word is taken plus stall cycles.
  task automatic send(input logic [31:0] w, input bit is_data,
                      input logic [ADDR_W-1:0] addr, input int stall);
    int n = 0;
    int st;
    st = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got s_ready %b, expected 1 within 50 cycles", s_ready);
    end else begin
      @(posedge clk);
      if (is_data) begin
        exp_q.push_back('{addr, w});
        exp_words += 32'd1;
        exp_sum   += w;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    s_data  = $urandom;
    repeat (st) @(negedge clk);
  endtask

  task automatic send_block(input logic [ADDR_W-1:0] base, input int cnt,
                            input int stall, input bit poke_start);
    logic [31:0]       w;
    logic [31:0]       d;
    logic [ADDR_W-1:0] a;
    w = $urandom;
    w[ADDR_W-1:0] = base;
    send(w, 1'b0, '0, stall);
    w = $urandom;
    w[ADDR_W:0] = cnt[ADDR_W:0];
    start = poke_start;
    send(w, 1'b0, '0, stall);
    a = base;
    for (int i = 0; i < cnt; i++) begin
      d = (dq.size() > 0) ? dq.pop_front() : $urandom;
      send(d, 1'b1, a, stall);
      a = a + 1'b1;
    end
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_words = '0;
    exp_sum   = '0;
    check("sess_busy", 32'(busy), 32'd1);
    check("sess_cpu_rst", 32'(cpu_rst), 32'd1);
    check("sess_done", 32'(done), 32'd0);
    check("sess_ready", 32'(s_ready), 32'd1);
    check("sess_words", words_loaded, 32'd0);
    check("sess_sum", checksum, 32'd0);
  endtask

  task automatic finish_image(input int stall);
    int n = 0;
    send_block(14'($urandom), 0, stall, 1'b0);
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_cpu_rst", 32'(cpu_rst), 32'd0);
    check("fin_ready", 32'(s_ready), 32'd0);
    check("fin_words", words_loaded, exp_words);
    check("fin_sum", checksum, exp_sum);
    check("fin_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_words"}, words_loaded, 32'd0);
    check({tag, "_sum"}, checksum, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]       w;
    logic [ADDR_W-1:0] base;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    exp_words = '0; exp_sum = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst");
    @(negedge clk);

    // Basic load with fixed words.
    begin_session();
    dq.push_back(32'h00000013); dq.push_back(32'h00500093); dq.push_back(32'hFFFFFFFF);
    send_block(14'h0000, 3, 0, 1'b0);
    finish_image(0);
    check("basic_sum_const", checksum, 32'h005000A5);
    check("basic_words_const", words_loaded, 32'd3);

    // Address wrap at the top of the image space.
    begin_session();
    send_block(14'h3FFE, 3, 0, 1'b0);
    finish_image(0);

    // Two idle cycles between every word.
    begin_session();
    send_block(14'h0123, 5, 2, 1'b0);
    finish_image(2);

    // Multi-block image.
    begin_session();
    send_block(14'h0000, 2, 0, 1'b0);
    send_block(14'h2000, 3, 0, 1'b0);
    finish_image(0);
    check("multi_words_const", words_loaded, 32'd5);

    // Abort during the second data word of a 4-word block.
    begin_session();
    w = $urandom; w[ADDR_W-1:0] = 14'h0100;
    send(w, 1'b0, '0, 0);
    w = $urandom; w[ADDR_W:0] = 15'd4;
    send(w, 1'b0, '0, 0);
    send($urandom, 1'b1, 14'h0100, 0);
    s_valid = 1'b1;
    s_data  = $urandom;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset("abort");
    check("abort_pending", 32'(exp_q.size()), 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);

    // start and s_valid together in IDLE: the word must not be taken.
    start = 1'b1; s_valid = 1'b1; s_data = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b0;
    exp_words = '0; exp_sum = '0;
    check("idle_start_busy", 32'(busy), 32'd1);
    check("idle_start_ready", 32'(s_ready), 32'd1);
    send_block(14'h0040, 2, 0, 1'b0);
    finish_image(0);

    // Reload from DONE, then randomized images with start pokes while busy.
    for (int s = 0; s < 8; s++) begin
      begin_session();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        base = ($urandom_range(0, 1) == 1) ? 14'(16383 - $urandom_range(0, 3)) : 14'($urandom);
        send_block(base, int'($urandom_range(1, 6)), -1, $urandom_range(0, 3) == 0);
      end
      finish_image(-1);
    end

    repeat (3) @(negedge clk);
    check("end_pending", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
- Hardware program/data image loader for the single-cycle RISC-V top.
- Accepts a 32-bit word stream over a valid/ready handshake and writes each word into the IM and DM byte banks through a shared write port; both memories are mirrored at the same word address.
- Holds the CPU in reset until the image is complete, then releases it.
- Replaces simulator-side memory preloading, so the same image path works in synthesized and FPGA builds.

Parameters:
- ADDR_W, 14, word-address width; image space is 2^ADDR_W words and covers word 0x3FFF.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  loader can accept a word this cycle.
- mem_we  out  4  byte-lane write enable, bit n drives Memory_byte n of IM and DM.
- mem_addr  out  ADDR_W  word address for IM/DM.
- mem_wdata  out  32  write data; byte n goes to lane n.
- cpu_rst  out  1  active-high reset to the CPU.
- busy  out  1  session in progress.
- done  out  1  image complete, CPU released.
- words_loaded  out  32  data words written this session.
- checksum  out  32  mod-2^32 sum of data words written this session.

Behaviour:
- Reset values: state IDLE; s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, busy 0, done 0, words_loaded 0, checksum 0.
- Reset is asynchronous. Asserting it mid-load aborts the session and returns all outputs to reset values. Words already written stay in memory.
- Handshake: a transfer occurs on a rising edge where s_valid & s_ready = 1. s_data is ignored otherwise. s_ready is decoded from state: 1 in HDR_BASE, HDR_CNT and DATA; 0 in IDLE and DONE. No backpressure inside DATA.
- Stream format: blocks of {base word, count word, count data words}. A header with count = 0 terminates the image.
- IDLE:
  - start → HDR_BASE.
  - busy=1, done=0, cpu_rst=1; clear words_loaded and checksum.
- HDR_BASE: on transfer, latch ptr = s_data[ADDR_W-1:0]; go to HDR_CNT.
- HDR_CNT: on transfer, latch remaining = s_data[ADDR_W:0]; upper bits are ignored.
  - remaining = 0 → DONE.
  - otherwise → DATA.
- DATA, on each transfer:
  - Next cycle: mem_we = 4'hF for exactly one cycle, mem_addr = ptr, mem_wdata = s_data. Write latency is 1 cycle after the handshake edge.
  - ptr increments mod 2^ADDR_W, so 0x3FFF wraps to 0x0000.
  - remaining decrements.
  - words_loaded increments.
  - checksum += s_data, mod 2^32.
  - When remaining reaches 0 after this transfer → HDR_BASE for the next block.
- Outside a write cycle, mem_we = 0 and mem_addr/mem_wdata hold their last values.
- DONE:
  - Registered on entry: cpu_rst=0, done=1, busy=0. The CPU starts fetching at pc 0 on the first edge after cpu_rst falls.
  - Stays in DONE until rst or start.
- start while in DONE: reload. Go to HDR_BASE, cpu_rst=1, done=0, busy=1, clear the counters.
- start while busy (HDR_BASE, HDR_CNT, DATA): ignored.
- start and s_valid in the same cycle in IDLE: no transfer that cycle, because s_ready is 0.
- Overlapping blocks are allowed; a later write to the same address wins.

Test Plan:
- Reset check: assert rst for 1 cycle → cpu_rst=1, s_ready=0, mem_we=0, done=0, busy=0, checksum=0, words_loaded=0.
- Basic load: start; stream 0x0, 3, 0x00000013, 0x00500093, 0xFFFFFFFF, then 0x0, 0 → three single-cycle mem_we=F pulses at addr 0, 1, 2 with matching data. checksum=0x005000A5, words_loaded=3, done=1, cpu_rst=0, busy=0.
- Wrap-around: block base 0x3FFE, count 3, data A, B, C, then terminator → writes at 0x3FFE, 0x3FFF, 0x0000 in that order.
- Stall: s_valid low for 2 cycles between every data word → mem_we pulses only after handshakes, no duplicate or dropped words, addresses strictly consecutive.
- Multi-block: blocks (0x0, 2 words) and (0x2000, 3 words), then terminator → 5 writes at 0, 1, 0x2000, 0x2001, 0x2002. words_loaded=5, checksum equals the sum of the 5 words.
- Abort and reload:
  - rst during the second data word of a 4-word block → all outputs at reset values; the first word stays written.
  - A later full load then start in DONE → cpu_rst returns to 1, state HDR_BASE, counters cleared.
